pipe_ctrl: RTL and testbench

PIPE_CTRL -- requirements
Module: pipe_ctrl

---
 rtl/core_pkg.sv | 23 ++
 rtl/sat_counter.sv | 28 ++
 rtl/pipe_ctrl.sv | 111 +++++++++++
 tb/tb_pipe_ctrl.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared pipeline-control definitions: stage indices, stall source IDs, and
// the drain/halt state machine encoding.
package core_pkg;

  localparam logic [2:0] STG_F = 3'd0;
  localparam logic [2:0] STG_D = 3'd1;
  localparam logic [2:0] STG_A = 3'd2;
  localparam logic [2:0] STG_C = 3'd3;
  localparam logic [2:0] STG_W = 3'd4;

  localparam int SRC_ICACHE = 0;
  localparam int SRC_LOAD   = 1;
  localparam int SRC_BRANCH = 2;
  localparam int SRC_MUL    = 3;
  localparam int SRC_DCACHE = 4;

  typedef enum logic [1:0] {
    ST_RUN,
    ST_DRAIN,
    ST_HALTED
  } pipe_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
  parameter int CNT_W = 32
) (
  input  logic             clock,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/pipe_ctrl.sv
// In-order pipeline controller: stall priority, bubble injection, redirect
// acceptance, drain-and-halt sequencing and per-source stall counters.
module pipe_ctrl
  import core_pkg::*;
#(
  parameter int                   NUM_STAGES     = int'(STG_W) + 1,
  parameter int                   NUM_SRC        = SRC_DCACHE + 1,
  parameter logic [NUM_SRC*3-1:0] SRC_STAGE      = {STG_C, STG_A, STG_D, STG_D, STG_F},
  parameter int                   REDIRECT_STAGE = 1,
  parameter int                   CNT_W          = 32
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       stall_req,
  input  logic                     redirect_en,
  input  logic                     halt_req,
  input  logic                     cnt_clear,
  output logic [NUM_STAGES-1:0]    stage_en,
  output logic [NUM_STAGES-1:0]    stage_bubble,
  output logic                     redirect_ack,
  output logic [NUM_STAGES-1:0]    stage_valid,
  output logic                     halted,
  output logic [NUM_SRC*CNT_W-1:0] stall_cnt
);

  pipe_state_e               state_q, state_d;
  logic [NUM_STAGES-1:1]     valid_q, valid_d;
  logic [NUM_STAGES-1:0]     en, bubble, cur_valid;
  logic                      ack;
  int                        s;

  // Highest stage owning an active stall; -1 when nothing stalls.
  always_comb begin
    s = -1;
    for (int unsigned k = 0; k < NUM_SRC; k++) begin
      if (stall_req[k] && (int'(SRC_STAGE[3*k +: 3]) > s)) begin
        s = int'(SRC_STAGE[3*k +: 3]);
      end
    end
  end

  always_comb begin
    ack    = redirect_en && (s < REDIRECT_STAGE);
    en     = '0;
    bubble = '0;
    for (int unsigned i = 0; i < NUM_STAGES; i++) begin
      en[i] = (state_q != ST_HALTED) && (int'(i) > s);
      if ((s >= 0) && (int'(i) == s + 1)) begin
        bubble[i] = 1'b1;
      end
      if (ack && (i >= 1) && (int'(i) <= REDIRECT_STAGE)) begin
        bubble[i] = 1'b1;
      end
    end
    if (state_q != ST_RUN) begin
      bubble[1] = 1'b1;
    end
    cur_valid = {valid_q, state_q == ST_RUN};
  end

  always_comb begin
    valid_d = valid_q;
    for (int unsigned i = 1; i < NUM_STAGES; i++) begin
      if (en[i]) begin
        valid_d[i] = cur_valid[i-1] & ~bubble[i];
      end
    end
    state_d = state_q;
    unique case (state_q)
      ST_RUN: begin
        if (halt_req) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        if ((valid_q == '0) && (stall_req == '0)) state_d = ST_HALTED;
        else if (!halt_req)                       state_d = ST_RUN;
      end
      ST_HALTED: begin
        if (!halt_req) state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase
    if (reset) begin
      state_d = ST_RUN;
      valid_d = '0;
    end
  end

  always_ff @(posedge clock) begin
    state_q <= state_d;
    valid_q <= valid_d;
  end

  // Live-input-driven outputs are forced quiet while reset is held.
  assign stage_en     = reset ? '0 : en;
  assign stage_bubble = reset ? '0 : bubble;
  assign redirect_ack = ack && !reset;
  assign stage_valid  = reset ? {valid_q, 1'b0} : cur_valid;
  assign halted       = (state_q == ST_HALTED);

  for (genvar k = 0; k < NUM_SRC; k++) begin : g_cnt
    sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clock(clock),
      .inc  (stall_req[k]),
      .clr  (reset | cnt_clear),
      .count(stall_cnt[k*CNT_W +: CNT_W])
    );
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: a stage-occupancy reference model predicts
// every cycle's outputs; a negedge monitor compares them against the DUT.
module tb_pipe_ctrl;
  import core_pkg::*;

  localparam int N    = 5;
  localparam int NS   = 5;
  localparam int CW   = 4;
  localparam int RS   = 1;
  localparam int CMAX = (1 << CW) - 1;

  localparam int M_RUN   = 0;
  localparam int M_DRAIN = 1;
  localparam int M_HALT  = 2;

  localparam logic [NS-1:0] B_ICACHE = NS'(1) << SRC_ICACHE;
  localparam logic [NS-1:0] B_LOAD   = NS'(1) << SRC_LOAD;
  localparam logic [NS-1:0] B_MUL    = NS'(1) << SRC_MUL;
  localparam logic [NS-1:0] B_DCACHE = NS'(1) << SRC_DCACHE;

  logic              clock = 1'b0;
  logic              reset;
  logic [NS-1:0]     stall_req;
  logic              redirect_en, halt_req, cnt_clear;
  logic [N-1:0]      stage_en, stage_bubble, stage_valid;
  logic              redirect_ack, halted;
  logic [NS*CW-1:0]  stall_cnt;

  always #5 clock = ~clock;

  pipe_ctrl #(
    .NUM_STAGES    (N),
    .NUM_SRC       (NS),
    .REDIRECT_STAGE(RS),
    .CNT_W         (CW)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .stall_req   (stall_req),
    .redirect_en (redirect_en),
    .halt_req    (halt_req),
    .cnt_clear   (cnt_clear),
    .stage_en    (stage_en),
    .stage_bubble(stage_bubble),
    .redirect_ack(redirect_ack),
    .stage_valid (stage_valid),
    .halted      (halted),
    .stall_cnt   (stall_cnt)
  );

  typedef struct {
    int              cyc;
    logic [N-1:0]    en;
    logic [N-1:0]    bub;
    logic [N-1:0]    vld;
    logic            ack;
    logic            hlt;
    logic [NS*CW-1:0] cnt;
  } exp_t;

  exp_t         exp_q[$];
  exp_t         me;
  int           n_tests = 0;
  int           n_fail  = 0;
  int           cyc_no  = 0;
  int           src_stage[NS];
  int           mode;
  logic [N-1:0] m_vld;
  int           mcnt[NS];
  logic         last_ack;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp, input int c);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h, expected %0h", nm, c, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, predict outputs, advance the model.
  task automatic cyc(input logic [NS-1:0] st, input logic rd, input logic hl,
                     input logic cl, input logic rs);
    int           s, en_i, bub_i;
    logic [N-1:0] en, bub, cur, nv;
    exp_t         e;
    @(posedge clock);
    #1;
    stall_req = st; redirect_en = rd; halt_req = hl; cnt_clear = cl; reset = rs;
    cyc_no++;

    s = -1;
    for (int k = 0; k < NS; k++)
      if (st[k] && src_stage[k] > s) s = src_stage[k];
    en_i  = ((1 << N) - 1) & ~((1 << (s + 1)) - 1);
    en    = (mode == M_HALT) ? '0 : en_i[N-1:0];
    e.ack = rd && (s < RS);
    bub_i = 0;
    if (s >= 0 && s + 1 < N) bub_i = bub_i | (1 << (s + 1));
    if (e.ack) for (int i = 1; i <= RS; i++) bub_i = bub_i | (1 << i);
    if (mode != M_RUN) bub_i = bub_i | 2;
    bub = bub_i[N-1:0];
    cur = {m_vld[N-1:1], mode == M_RUN};

    e.cyc = cyc_no;
    e.hlt = (mode == M_HALT);
    for (int k = 0; k < NS; k++) e.cnt[k*CW +: CW] = CW'(mcnt[k]);
    if (rs) begin
      e.en  = '0;
      e.bub = '0;
      e.ack = 1'b0;
      e.vld = {m_vld[N-1:1], 1'b0};
    end else begin
      e.en  = en;
      e.bub = bub;
      e.vld = cur;
    end
    exp_q.push_back(e);
    last_ack = e.ack;

    if (rs) begin
      mode  = M_RUN;
      m_vld = '0;
      for (int k = 0; k < NS; k++) mcnt[k] = 0;
    end else begin
      nv = m_vld;
      for (int i = 1; i < N; i++)
        if (en[i]) nv[i] = cur[i-1] & ~bub[i];
      case (mode)
        M_RUN:   if (hl) mode = M_DRAIN;
        M_DRAIN: begin
          if (m_vld[N-1:1] == '0 && st == '0) mode = M_HALT;
          else if (!hl)                       mode = M_RUN;
        end
        default: if (!hl) mode = M_RUN;
      endcase
      m_vld = nv;
      for (int k = 0; k < NS; k++) begin
        if (cl)         mcnt[k] = 0;
        else if (st[k]) mcnt[k] = (mcnt[k] == CMAX) ? CMAX : mcnt[k] + 1;
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clock);
      if (exp_q.size() > 0) begin
        me = exp_q.pop_front();
        chk("stage_en",     32'(stage_en),     32'(me.en),  me.cyc);
        chk("stage_bubble", 32'(stage_bubble), 32'(me.bub), me.cyc);
        chk("stage_valid",  32'(stage_valid),  32'(me.vld), me.cyc);
        chk("redirect_ack", 32'(redirect_ack), 32'(me.ack), me.cyc);
        chk("halted",       32'(halted),       32'(me.hlt), me.cyc);
        chk("stall_cnt",    32'(stall_cnt),    32'(me.cnt), me.cyc);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [NS-1:0] st;
    logic          rd_pend, hl, cl, rs;

    src_stage[SRC_ICACHE] = 0;
    src_stage[SRC_LOAD]   = 1;
    src_stage[SRC_BRANCH] = 1;
    src_stage[SRC_MUL]    = 2;
    src_stage[SRC_DCACHE] = 3;
    mode  = M_RUN;
    m_vld = '0;
    for (int k = 0; k < NS; k++) mcnt[k] = 0;

    reset = 1'b1; stall_req = '0; redirect_en = 1'b0; halt_req = 1'b0; cnt_clear = 1'b0;
    repeat (2) @(posedge clock);

    cyc('0, 0, 0, 0, 1);
    repeat (6) cyc('0, 0, 0, 0, 0);
    // Single mul stall, then load+dcache together.
    repeat (4) cyc(B_MUL, 0, 0, 0, 0);
    repeat (3) cyc(B_LOAD | B_DCACHE, 0, 0, 0, 0);
    // Redirect held across a dcache stall, accepted when it drops.
    repeat (3) cyc(B_DCACHE, 1, 0, 0, 0);
    cyc('0, 1, 0, 0, 0);
    repeat (2) cyc('0, 0, 0, 0, 0);
    // Drain and halt with a full pipeline, then resume.
    repeat (5) cyc('0, 0, 0, 0, 0);
    repeat (12) cyc('0, 0, 1, 0, 0);
    repeat (3) cyc('0, 0, 0, 0, 0);
    // Counter saturation and clear-over-increment.
    repeat (20) cyc(B_ICACHE, 0, 0, 0, 0);
    cyc(B_ICACHE, 0, 0, 1, 0);
    repeat (2) cyc(B_ICACHE, 0, 0, 0, 0);
    cyc('0, 0, 0, 0, 0);
    // Reset in the middle of a drain.
    repeat (3) cyc('0, 0, 0, 0, 0);
    repeat (2) cyc(B_LOAD, 0, 1, 0, 0);
    cyc(B_LOAD, 0, 1, 0, 1);
    repeat (3) cyc('0, 0, 0, 0, 0);

    rd_pend = 1'b0;
    hl      = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      st = '0;
      for (int k = 0; k < NS; k++) if ($urandom_range(0, 9) == 0) st[k] = 1'b1;
      if (!rd_pend && $urandom_range(0, 7) == 0) rd_pend = 1'b1;
      if ($urandom_range(0, 29) == 0) hl = ~hl;
      cl = ($urandom_range(0, 49) == 0);
      rs = ($urandom_range(0, 249) == 0);
      cyc(st, rd_pend, hl, cl, rs);
      if (last_ack) rd_pend = 1'b0;
    end

    repeat (3) @(posedge clock);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
